// File: rtl/iob_fp_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iob_fp_addsub                                                 |
// | Brief    : 5-stage pipelined IEEE-754-style add/subtract, DAZ/FTZ, RNE   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module iob_fp_addsub #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              sub_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              exception_o
);

    localparam int C_F    = DATA_W - EXP_W - 1;
    localparam int C_M    = C_F + 1;
    localparam int C_X    = C_F + 4;
    localparam int C_LZ_W = $clog2(C_X + 1);
    localparam int C_EW   = EXP_W + 2;
    localparam logic [EXP_W-1:0] C_EXP_MAX   = '1;
    localparam logic [EXP_W-1:0] C_SHIFT_SAT = EXP_W'(C_F + 3);
    localparam logic [C_EW-1:0]  C_ONE       = C_EW'(1);
    localparam logic [C_EW-1:0]  C_INF_EXP   = {2'b00, C_EXP_MAX};

    // ---------------- stage 0: unpack, classify, order ----------------
    logic              w_sign_a, w_sign_b;
    logic [EXP_W-1:0]  w_exp_a, w_exp_b;
    logic [C_F-1:0]    w_frac_a, w_frac_b;
    logic              w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic              w_a_ge_b;
    logic              w_special, w_spec_exc;
    logic [DATA_W-1:0] w_spec_res;

    assign w_sign_a = op_a_i[DATA_W-1];
    assign w_sign_b = op_b_i[DATA_W-1] ^ sub_i;
    assign w_exp_a  = op_a_i[DATA_W-2:C_F];
    assign w_exp_b  = op_b_i[DATA_W-2:C_F];
    assign w_frac_a = op_a_i[C_F-1:0];
    assign w_frac_b = op_b_i[C_F-1:0];
    assign w_zero_a = (w_exp_a == '0);
    assign w_zero_b = (w_exp_b == '0);
    assign w_inf_a  = (w_exp_a == C_EXP_MAX) && (w_frac_a == '0);
    assign w_inf_b  = (w_exp_b == C_EXP_MAX) && (w_frac_b == '0);
    assign w_nan_a  = (w_exp_a == C_EXP_MAX) && (w_frac_a != '0);
    assign w_nan_b  = (w_exp_b == C_EXP_MAX) && (w_frac_b != '0);
    assign w_a_ge_b = (op_a_i[DATA_W-2:0] >= op_b_i[DATA_W-2:0]);

    always_comb begin
        w_special  = 1'b1;
        w_spec_exc = 1'b0;
        w_spec_res = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b))) begin
            w_spec_res = {1'b0, C_EXP_MAX, 1'b1, {(C_F-1){1'b0}}};
            w_spec_exc = 1'b1;
        end else if (w_inf_a) begin
            w_spec_res = {w_sign_a, C_EXP_MAX, {C_F{1'b0}}};
        end else if (w_inf_b) begin
            w_spec_res = {w_sign_b, C_EXP_MAX, {C_F{1'b0}}};
        end else if (w_zero_a && w_zero_b) begin
            w_spec_res = {w_sign_a & w_sign_b, {(DATA_W-1){1'b0}}};
        end else if (w_zero_a) begin
            w_spec_res = {w_sign_b, op_b_i[DATA_W-2:0]};
        end else if (w_zero_b) begin
            w_spec_res = op_a_i;
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- pipeline registers ----------------
    logic              r1_valid, r2_valid, r3_valid, r4_valid;
    logic              r1_special, r2_special, r3_special, r4_special;
    logic              r1_spec_exc, r2_spec_exc, r3_spec_exc, r4_spec_exc;
    logic [DATA_W-1:0] r1_spec_res, r2_spec_res, r3_spec_res, r4_spec_res;
    logic              r1_sign, r2_sign, r3_sign, r4_sign;
    logic              r1_sub, r2_sub;
    logic [EXP_W-1:0]  r1_exp, r2_exp, r3_exp;
    logic [EXP_W-1:0]  r1_diff;
    logic [C_M-1:0]    r1_man_a, r1_man_b;
    logic [C_X-1:0]    r2_man_a, r2_man_b;
    logic [C_X:0]      r3_sum;
    logic [C_X-1:0]    r4_norm;
    logic [C_EW-1:0]   r4_exp;

    // ---------------- stage 1 -> 2: alignment with guard/round/sticky ----------------
    logic [EXP_W-1:0]  w_shamt;
    logic [2*C_X-1:0]  w_align;
    logic [C_X-1:0]    w_b_aligned;

    assign w_shamt     = (r1_diff > C_SHIFT_SAT) ? C_SHIFT_SAT : r1_diff;
    assign w_align     = {r1_man_b, 3'b000, {C_X{1'b0}}} >> w_shamt;
    assign w_b_aligned = {w_align[2*C_X-1:C_X+1], w_align[C_X] | (|w_align[C_X-1:0])};

    // ---------------- stage 2 -> 3: significand add/sub ----------------
    logic [C_X:0] w_sum;

    assign w_sum = r2_sub ? ({1'b0, r2_man_a} - {1'b0, r2_man_b})
                          : ({1'b0, r2_man_a} + {1'b0, r2_man_b});

    // ---------------- stage 3 -> 4: normalisation ----------------
    logic [C_LZ_W-1:0] w_lzc;
    logic              w_found;
    logic [C_X-1:0]    w_norm;
    logic [C_EW-1:0]   w_exp_n;

    always_comb begin
        w_lzc   = '0;
        w_found = 1'b0;
        for (int i = C_X - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (r3_sum[i]) w_found = 1'b1;
                else           w_lzc   = w_lzc + C_LZ_W'(1);
            end
        end
    end

    always_comb begin
        if (r3_sum[C_X]) begin
            w_norm  = {r3_sum[C_X:2], r3_sum[1] | r3_sum[0]};
            w_exp_n = {2'b00, r3_exp} + C_ONE;
        end else begin
            w_norm  = r3_sum[C_X-1:0] << w_lzc;
            w_exp_n = {2'b00, r3_exp} - {{(C_EW-C_LZ_W){1'b0}}, w_lzc};
        end
    end

    // ---------------- stage 4 -> out: rounding and result select ----------------
    // A clear hidden bit after normalisation can only mean an all-zero difference.
    logic              w_round_up;
    logic [C_F:0]      w_frac_r;
    logic [C_EW-1:0]   w_exp_r;
    logic [DATA_W-1:0] w_res;
    logic              w_ovf, w_uf, w_exc;

    assign w_round_up = r4_norm[2] & (r4_norm[1] | r4_norm[0] | r4_norm[3]);
    assign w_frac_r   = {1'b0, r4_norm[C_X-2:3]} + {{C_F{1'b0}}, w_round_up};
    assign w_exp_r    = r4_exp + {{(C_EW-1){1'b0}}, w_frac_r[C_F]};

    always_comb begin
        w_res = {r4_sign, w_exp_r[EXP_W-1:0], w_frac_r[C_F-1:0]};
        w_ovf = 1'b0;
        w_uf  = 1'b0;
        w_exc = 1'b0;
        if (r4_special) begin
            w_res = r4_spec_res;
            w_exc = r4_spec_exc;
        end else if (!r4_norm[C_X-1]) begin
            w_res = '0;
        end else if ($signed(r4_exp) < $signed(C_ONE)) begin
            w_res = {r4_sign, {(DATA_W-1){1'b0}}};
            w_uf  = 1'b1;
        end else if ($signed(w_exp_r) >= $signed(C_INF_EXP)) begin
            w_res = {r4_sign, C_EXP_MAX, {C_F{1'b0}}};
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r3_valid    <= 1'b0;
            r4_valid    <= 1'b0;
            done_o      <= 1'b0;
            res_o       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            exception_o <= 1'b0;
        end else begin
            r1_valid <= start_i;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
            r4_valid <= r3_valid;
            done_o   <= r4_valid;
            if (r4_valid) begin
                res_o       <= w_res;
                overflow_o  <= w_ovf;
                underflow_o <= w_uf;
                exception_o <= w_exc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r1_special  <= w_special;
        r1_spec_exc <= w_spec_exc;
        r1_spec_res <= w_spec_res;
        r1_sub      <= w_sign_a ^ w_sign_b;
        if (w_a_ge_b) begin
            r1_sign  <= w_sign_a;
            r1_exp   <= w_exp_a;
            r1_diff  <= w_exp_a - w_exp_b;
            r1_man_a <= {1'b1, w_frac_a};
            r1_man_b <= {1'b1, w_frac_b};
        end else begin
            r1_sign  <= w_sign_b;
            r1_exp   <= w_exp_b;
            r1_diff  <= w_exp_b - w_exp_a;
            r1_man_a <= {1'b1, w_frac_b};
            r1_man_b <= {1'b1, w_frac_a};
        end

        r2_special  <= r1_special;
        r2_spec_exc <= r1_spec_exc;
        r2_spec_res <= r1_spec_res;
        r2_sign     <= r1_sign;
        r2_sub      <= r1_sub;
        r2_exp      <= r1_exp;
        r2_man_a    <= {r1_man_a, 3'b000};
        r2_man_b    <= w_b_aligned;

        r3_special  <= r2_special;
        r3_spec_exc <= r2_spec_exc;
        r3_spec_res <= r2_spec_res;
        r3_sign     <= r2_sign;
        r3_exp      <= r2_exp;
        r3_sum      <= w_sum;

        r4_special  <= r3_special;
        r4_spec_exc <= r3_spec_exc;
        r4_spec_res <= r3_spec_res;
        r4_sign     <= r3_sign;
        r4_exp      <= w_exp_n;
        r4_norm     <= w_norm;
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_fp_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_iob_fp_addsub                                              |
// | Brief    : self-checking bench, exact-arithmetic reference model         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_iob_fp_addsub;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        sub_i = 1'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        done_o;
    logic [31:0] res_o;
    logic        overflow_o, underflow_o, exception_o;

    iob_fp_addsub #(.DATA_W(32), .EXP_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .sub_i       (sub_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .done_o      (done_o),
        .res_o       (res_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .exception_o (exception_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [34:0] exp;   // {result, overflow, underflow, exception}
    } item_t;

    item_t q[$];
    int    cycle = 0;
    int    n_vec = 0;
    int    n_err = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Exact value of both operands on a common integer grid, then one RNE rounding.
    function automatic logic [34:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub);
        logic         sa, sb, sr;
        logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        int           ea, eb, emin, p, e, sh;
        logic [299:0] x, y, s, qv, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) return {32'h7FC00000, 3'b001};
        if (inf_a) return {sa, 8'hFF, 23'h0, 3'b000};
        if (inf_b) return {sb, 8'hFF, 23'h0, 3'b000};
        if (zero_a && zero_b) return {sa & sb, 31'h0, 3'b000};
        if (zero_a) return {sb, b[30:0], 3'b000};
        if (zero_b) return {a, 3'b000};
        emin = (ea < eb) ? ea : eb;
        x = 300'({1'b1, a[22:0]}) << (ea - emin);
        y = 300'({1'b1, b[22:0]}) << (eb - emin);
        if (sa == sb)  begin s = x + y; sr = sa; end
        else if (x >= y) begin s = x - y; sr = sa; end
        else           begin s = y - x; sr = sb; end
        if (s == 0) return 35'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (s[i]) p = i;
        e = emin + p - 23;
        if (e < 1) return {sr, 31'h0, 3'b010};
        if (p > 23) begin
            sh   = p - 23;
            qv   = s >> sh;
            rem  = s - (qv << sh);
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && qv[0])) qv = qv + 300'(1);
            if (qv[24]) begin qv = qv >> 1; e = e + 1; end
        end else begin
            qv = s << (23 - p);
        end
        if (e >= 255) return {sr, 8'hFF, 23'h0, 3'b100};
        return {sr, e[7:0], qv[22:0], 3'b000};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got {done,res,ovf,uf,exc}=%h, required %h",
                     name, cycle, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        item_t it;
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        start_i = 1'b1;
        sub_i   = s;
        op_a_i  = a;
        op_b_i  = b;
        it.due  = cycle + 5;
        it.exp  = fp_model(a, b, s);
        q.push_back(it);
    endtask

    // Pins the model against a hand-computed literal, then sends the vector.
    task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [34:0] lit);
        check({"model_", name}, {1'b0, fp_model(a, b, s)}, {1'b0, lit});
        issue(a, b, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
    endtask

    // Single compare process: every cycle after the first edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cycle) begin
                check("result", {done_o, res_o, overflow_o, underflow_o, exception_o},
                      {1'b1, q[0].exp});
                void'(q.pop_front());
            end else begin
                check("idle_done", {35'h0, done_o}, 36'h0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {done_o, res_o, overflow_o, underflow_o, exception_o}, 36'h0);

        vec("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, {32'h40400000, 3'b000});
        idle(2);
        vec("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, {32'h40000000, 3'b000});
        vec("sub_equal", 32'h3F800000, 32'h3F800000, 1'b1, {32'h00000000, 3'b000});
        vec("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {32'h7F800000, 3'b100});
        vec("underflow", 32'h00800001, 32'h00800000, 1'b1, {32'h00000000, 3'b010});
        vec("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, {32'h7FC00000, 3'b001});
        vec("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, {32'h7FC00000, 3'b001});
        vec("cancel_ulp",32'h3F800001, 32'h3F800000, 1'b1, {32'h34000000, 3'b000});
        idle(7);

        // eight back-to-back operations, normal and special mixed
        vec("mixed_sign", 32'h3FC00000, 32'hBF400000, 1'b0, {32'h3F400000, 3'b000});
        vec("neg_zeros",  32'h80000000, 32'h80000000, 1'b0, {32'h80000000, 3'b000});
        vec("zero_m_b",   32'h00000000, 32'h40000000, 1'b1, {32'hC0000000, 3'b000});
        vec("inf_m_one",  32'h7F800000, 32'h3F800000, 1'b1, {32'h7F800000, 3'b000});
        vec("tie_even",   32'h3F800000, 32'h33800000, 1'b0, {32'h3F800000, 3'b000});
        vec("above_half", 32'h3F800000, 32'h33800001, 1'b0, {32'h3F800001, 3'b000});
        vec("denorm_daz", 32'h00123456, 32'h3F800000, 1'b0, {32'h3F800000, 3'b000});
        vec("round_carry",32'h4B7FFFFF, 32'h3F000000, 1'b0, {32'h4B800000, 3'b000});
        issue(32'h40490FDB, 32'h402DF854, 1'b0);
        issue(32'h00800000, 32'h00800000, 1'b0);
        issue(32'hC2F6E979, 32'h4479C000, 1'b1);
        idle(8);

        // reset with three operations in flight
        issue(32'h3F800000, 32'h40000000, 1'b0);
        issue(32'h40400000, 32'h3F800000, 1'b1);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        rst_i   = 1'b1;
        q.delete();
        issue(32'h40A00000, 32'h40400000, 1'b1);
        @(negedge clk);
        check("reset_flush", {done_o, res_o, overflow_o, underflow_o, exception_o}, 36'h0);
        idle(1);

        for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results still pending, required 0", q.size());
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
